// File: rtl/apb_pkg.sv
// Shared state encoding and default bus widths for the APB master arbiter.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module apb_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit so ptr+i can exceed N_REQ-1 before the wrap subtract.
            sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
            idx = sum[IDX_W-1:0];
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o = idx;
            end
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB slave port between N_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing with a bounded wait on pready, and a registered completion pulse per winner.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     pclk_i,
    input  logic                     preset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_write_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic                     rsp_err_o,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic [ADDR_W-1:0]        paddr_o,
    output logic                     psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    output logic [DATA_W-1:0]        pwdata_o,
    input  logic [DATA_W-1:0]        prdata_i,
    input  logic                     pready_i
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    apb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic [N_REQ-1:0]  done_oh;

    apb_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign done_oh = N_REQ'(1) << win_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        wcnt_d      = wcnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = SETUP;
                    win_d   = gnt_idx;
                    wcnt_d  = '0;
                    psel_d  = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt[i]) begin
                            pwrite_d = req_write_i[i];
                            paddr_d  = req_addr_i[i*ADDR_W +: ADDR_W];
                            pwdata_d = req_wdata_i[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d     = RESP;
                    rsp_valid_d = done_oh;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                end else if (wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: psel falls with no pready, so the slave never completes it.
                    state_d     = RESP;
                    rsp_valid_d = done_oh;
                    rsp_err_d   = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    wcnt_d    = wcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            wcnt_q      <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            wcnt_q      <= wcnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign paddr_o     = paddr_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
endmodule
